// File: rtl/uart_cmd_wrapper.sv
// UART plus two-byte command assembler; cmd/cmd_rdy update one clk after the low byte's rx_rdy.
// No backpressure: a new command overwrites an unconsumed one. Define CMD_TIMEOUT_EN for the inter-byte timeout.
module uart #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic       TX,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done,
   output logic       rx_rdy,
   output logic [7:0] rx_data,
   input  logic       clr_rx_rdy
);
   localparam int CW = $clog2(2 * BAUD_DIV);

   logic [1:0]    rx_sync_q, rx_sync_d;
   logic          rx_busy_q, rx_busy_d;
   logic [CW-1:0] rx_baud_q, rx_baud_d;
   logic [3:0]    rx_bits_q, rx_bits_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_rdy_q, rx_rdy_d;
   logic          tx_busy_q, tx_busy_d;
   logic [CW-1:0] tx_baud_q, tx_baud_d;
   logic [3:0]    tx_bits_q, tx_bits_d;
   logic [9:0]    tx_shift_q, tx_shift_d;
   logic          tx_done_q, tx_done_d;

   always_comb begin
      rx_sync_d  = {rx_sync_q[0], RX};
      rx_busy_d  = rx_busy_q;
      rx_baud_d  = rx_baud_q;
      rx_bits_d  = rx_bits_q;
      rx_shift_d = rx_shift_q;
      rx_rdy_d   = rx_rdy_q & ~clr_rx_rdy;
      // First sample lands 1.5 bit times after the start edge, mid data bit 0
      if (!rx_busy_q) begin
         if (!rx_sync_q[1]) begin
            rx_busy_d = 1'b1;
            rx_baud_d = CW'(BAUD_DIV + BAUD_DIV / 2 - 1);
            rx_bits_d = 4'd9;
            rx_rdy_d  = 1'b0;
         end
      end else if (rx_baud_q != '0) begin
         rx_baud_d = rx_baud_q - 1'b1;
      end else begin
         rx_baud_d = CW'(BAUD_DIV - 1);
         rx_bits_d = rx_bits_q - 4'd1;
         if (rx_bits_q == 4'd1) begin
            rx_busy_d = 1'b0;
            rx_rdy_d  = 1'b1;
         end else begin
            rx_shift_d = {rx_sync_q[1], rx_shift_q[7:1]};
         end
      end

      tx_busy_d  = tx_busy_q;
      tx_baud_d  = tx_baud_q;
      tx_bits_d  = tx_bits_q;
      tx_shift_d = tx_shift_q;
      tx_done_d  = 1'b0;
      // trmt while a frame is in flight is ignored
      if (!tx_busy_q) begin
         if (trmt) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, tx_data, 1'b0};
            tx_baud_d  = CW'(BAUD_DIV - 1);
            tx_bits_d  = 4'd10;
         end
      end else if (tx_baud_q != '0) begin
         tx_baud_d = tx_baud_q - 1'b1;
      end else begin
         tx_shift_d = {1'b1, tx_shift_q[9:1]};
         tx_baud_d  = CW'(BAUD_DIV - 1);
         tx_bits_d  = tx_bits_q - 4'd1;
         if (tx_bits_q == 4'd1) begin
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_q  <= 2'b11;
         rx_busy_q  <= 1'b0;
         rx_baud_q  <= '0;
         rx_bits_q  <= '0;
         rx_shift_q <= '0;
         rx_rdy_q   <= 1'b0;
         tx_busy_q  <= 1'b0;
         tx_baud_q  <= '0;
         tx_bits_q  <= '0;
         tx_shift_q <= '1;
         tx_done_q  <= 1'b0;
      end else begin
         rx_sync_q  <= rx_sync_d;
         rx_busy_q  <= rx_busy_d;
         rx_baud_q  <= rx_baud_d;
         rx_bits_q  <= rx_bits_d;
         rx_shift_q <= rx_shift_d;
         rx_rdy_q   <= rx_rdy_d;
         tx_busy_q  <= tx_busy_d;
         tx_baud_q  <= tx_baud_d;
         tx_bits_q  <= tx_bits_d;
         tx_shift_q <= tx_shift_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign TX      = tx_shift_q[0];
   assign tx_done = tx_done_q;
   assign rx_rdy  = rx_rdy_q;
   assign rx_data = rx_shift_q;
endmodule

module uart_cmd_wrapper #(
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int BAUD_DIV       = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        trmt,
   input  logic [7:0]  resp,
   output logic        tx_done,
   output logic        timeout_err
);
   typedef enum logic {WAIT_HIGH, WAIT_LOW} state_t;

   logic       rx_rdy;
   logic [7:0] rx_data;
   logic       clr_rx_rdy;

   uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .trmt       (trmt),
      .tx_data    (resp),
      .tx_done    (tx_done),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .clr_rx_rdy (clr_rx_rdy)
   );

   // Every byte is consumed the cycle it appears, so the ack is rx_rdy itself
   assign clr_rx_rdy = rx_rdy;

   state_t      state_q, state_d;
   logic [15:0] cmd_q, cmd_d;
   logic        cmd_rdy_q, cmd_rdy_d;
`ifdef CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          timeout_err_q, timeout_err_d;
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt_d     = '0;
      timeout_err_d = 1'b0;
`endif
      case (state_q)
         WAIT_HIGH: begin
            if (rx_rdy) begin
               cmd_d[15:8] = rx_data;
               cmd_rdy_d   = 1'b0;
               state_d     = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
`ifdef CMD_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
            if (rx_rdy) begin
               cmd_d[7:0] = rx_data;
               cmd_rdy_d  = 1'b1;
               state_d    = WAIT_HIGH;
            end
`ifdef CMD_TIMEOUT_EN
            else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d       = WAIT_HIGH;
               timeout_err_d = 1'b1;
            end
`endif
         end
         default: state_d = WAIT_HIGH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= WAIT_HIGH;
         cmd_q     <= 16'h0000;
         cmd_rdy_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         cmd_rdy_q <= cmd_rdy_d;
`ifdef CMD_TIMEOUT_EN
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign cmd     = cmd_q;
   assign cmd_rdy = cmd_rdy_q;
`ifdef CMD_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif
endmodule

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 The block SHALL provide parameter TIMEOUT_CYCLES, default 20000, giving the maximum clk cycles allowed between the high byte and the low byte of one command.
REQ-002 Port clk, input, 1, system clock.
REQ-003 Port rst_n, input, 1, reset; rst_n SHALL be asynchronous and active-low, and clk SHALL be the clock.
REQ-004 Port RX, input, 1, serial receive line.
REQ-005 Port TX, output, 1, serial transmit line.
REQ-006 Port cmd, output, 16, assembled command, high byte in [15:8].
REQ-007 Port cmd_rdy, output, 1, high while a complete, unconsumed command is held on cmd.
REQ-008 Port clr_cmd_rdy, input, 1, consumer acknowledge that clears cmd_rdy.
REQ-009 Port trmt, input, 1, one-cycle request to transmit resp.
REQ-010 Port resp, input, 8, response byte to transmit.
REQ-011 Port tx_done, output, 1, response byte fully shifted out.
REQ-012 Port timeout_err, output, 1, one-cycle pulse when a partial command is discarded.

Function
REQ-013 The block SHALL instantiate the team UART: RX/TX to ports, trmt/resp/tx_done passed straight through, rx_rdy/rx_data/clr_rx_rdy used internally.
REQ-014 The FSM SHALL have two states: WAIT_HIGH (reset state) and WAIT_LOW.
REQ-015 In WAIT_HIGH with rx_rdy=1: capture rx_data into the high-byte register, pulse clr_rx_rdy, clear cmd_rdy, go to WAIT_LOW.
REQ-016 In WAIT_LOW with rx_rdy=1: capture rx_data into the low-byte register, pulse clr_rx_rdy, set cmd_rdy, go to WAIT_HIGH.
REQ-017 cmd SHALL be registered, changing only on byte capture; cmd_rdy SHALL rise on the clk edge after the low byte's rx_rdy is sampled.
REQ-018 cmd_rdy SHALL be an SR flop: cleared by clr_cmd_rdy or by high-byte capture; when set and clr_cmd_rdy occur in the same cycle, set SHALL win.
REQ-019 cmd[15:8] SHALL not change while cmd_rdy=1 unless a new high byte arrives, which clears cmd_rdy in the same edge.
REQ-020 clr_rx_rdy SHALL be a one-cycle pulse per received byte; no byte SHALL be captured twice.
REQ-021 Transmit and receive paths SHALL operate concurrently and independently; trmt while busy SHALL be handled by UART rules, with no wrapper-side queuing.

Reset
REQ-022 On rst_n low: state=WAIT_HIGH, cmd=16'h0000, cmd_rdy=0, timeout_err=0, timeout counter=0; TX SHALL idle high per the UART.
REQ-023 Reset asserted mid-command (in WAIT_LOW) SHALL discard the high byte; the next received byte SHALL be treated as a high byte.

Configuration
REQ-024 Macro CMD_TIMEOUT_EN SHALL compile in the inter-byte timeout.
REQ-025 With CMD_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT_LOW and increment each cycle in WAIT_LOW.
REQ-026 With CMD_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES-1 with rx_rdy=0, the FSM SHALL return to WAIT_HIGH, pulse timeout_err for one cycle, and leave cmd and cmd_rdy unchanged.
REQ-027 With CMD_TIMEOUT_EN defined: rx_rdy in the terminal-count cycle SHALL win, and the byte SHALL be accepted as the low byte.
REQ-028 Without CMD_TIMEOUT_EN: no counter SHALL exist, timeout_err SHALL be tied 0, and WAIT_LOW SHALL wait indefinitely.

Verification
REQ-029 Send 0xA5 then 0x3C -> cmd=16'hA53C, cmd_rdy=1 one cycle after the second rx_rdy, and each byte produces exactly one clr_rx_rdy pulse.
REQ-030 With cmd_rdy=1, pulse clr_cmd_rdy, then send 0x12,0x34 -> cmd_rdy=0 after the clear, cmd=16'h1234 with cmd_rdy=1 after the second byte.
REQ-031 Set and clr_cmd_rdy land in the same cycle -> cmd_rdy=1.
REQ-032 trmt with resp=0xA5 while a command is being received -> TX frame carries 0xA5, tx_done pulses, and the incoming command still assembles correctly.
REQ-033 CMD_TIMEOUT_EN defined, TIMEOUT_CYCLES=100: send 0x55, then wait 100 cycles -> one timeout_err pulse; then send 0x01,0x02 -> cmd=16'h0102.
REQ-034 Assert rst_n low after the high byte 0xFF, release, then send 0x0A,0x0B -> cmd=16'h0A0B with no stale 0xFF.
